// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared FSM encodings, register constants and control bundle
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic freeze;
    logic wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                 id_ex_flush: 1'b0, freeze: 1'b0, wb_bubble: 1'b0};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, freeze: 1'b0, wb_bubble: 1'b1};
  localparam ctrl_t CTRL_MEM_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, freeze: 1'b1, wb_bubble: 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, freeze: 1'b0, wb_bubble: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, freeze: 1'b0, wb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with memory-wait FSM and perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             freeze,
  output logic             wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      ST_RUN:      mem_stall = dmem_req && !dmem_ready;
      ST_MEM_WAIT: mem_stall = !dmem_ready;
      ST_ERROR:    mem_stall = 1'b1;
      default:     mem_stall = 1'b0;
    endcase
  end

  // A taken branch frozen in EX simply reappears here once the stall lifts
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n)
      ctrl = CTRL_RESET;
    else if (mem_stall)
      ctrl = CTRL_MEM_STALL;
    else if (ex_branch_taken)
      ctrl = CTRL_BRANCH;
    else if (load_use)
      ctrl = CTRL_LOAD_USE;
  end

  assign stall_inc = mem_stall || (!ex_branch_taken && load_use);
  assign flush_inc = !mem_stall && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready)
            state_q <= ST_RUN;
          else if (wait_cnt == WAIT_LAST)
            state_q <= ST_ERROR;
          else
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_RUN;
      endcase

      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign if_id_write = ctrl.if_id_write;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign freeze      = ctrl.freeze;
  assign wb_bubble   = ctrl.wb_bubble;
  assign mem_err     = (state_q == ST_ERROR);
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  localparam logic [5:0] E_RESET = 6'b001101;
  localparam logic [5:0] E_STALL = 6'b000011;
  localparam logic [5:0] E_BR    = 6'b111100;
  localparam logic [5:0] E_LU    = 6'b000100;
  localparam logic [5:0] E_RUN   = 6'b110000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          dmem_req, dmem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  bit m_err, m_wait;
  int m_waits, m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .freeze(freeze), .wb_bubble(wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_state"}, 32'(state), m_err ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
    chk({tag, "_mem_err"}, 32'(mem_err), 32'(m_err));
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
  endtask

  // inputs are set just after a rising edge; outputs checked mid-cycle, registers after the edge
  task automatic step(input string tag);
    bit hz, ms, br;
    logic [5:0] ec;
    hz = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    ms = m_err || (m_wait ? !dmem_ready : (dmem_req && !dmem_ready));
    br = ex_branch_taken;
    ec = ms ? E_STALL : br ? E_BR : hz ? E_LU : E_RUN;
    #2;
    chk({tag, "_ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, wb_bubble}), 32'(ec));
    @(posedge clk); #1;
    if (ms || (!br && hz)) m_stall = sat_inc(m_stall);
    if (!ms && br) m_flush = sat_inc(m_flush);
    if (!m_err) begin
      if (m_wait) begin
        if (dmem_ready) m_wait = 0;
        else begin
          m_waits++;
          if (m_waits == TO) begin m_err = 1; m_wait = 0; end
        end
      end else if (dmem_req && !dmem_ready) begin
        m_wait = 1; m_waits = 0;
      end
    end
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_rst_ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, wb_bubble}), 32'(E_RESET));
    @(posedge clk); #1;
    m_err = 0; m_wait = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    chk({tag, "_rst_state"}, 32'(state), 32'd0);
    chk({tag, "_rst_mem_err"}, 32'(mem_err), 32'd0);
    chk({tag, "_rst_stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_rst_flush"}, 32'(flush_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    do_reset("init");

    // load-use on rs2 stalls exactly one cycle
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    step("lu");
    chk("lu_stall_one", 32'(stall_cnt), 32'd1);
    clear_inputs();
    step("lu_after");

    // load to x0 never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    step("x0");
    chk("x0_no_stall", 32'(stall_cnt), 32'd1);
    clear_inputs();

    // branch outranks load-use
    do_reset("br");
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
    step("br_lu");
    chk("br_lu_flush", 32'(flush_cnt), 32'd1);
    chk("br_lu_stall", 32'(stall_cnt), 32'd0);
    clear_inputs();

    // branch held through a 3-cycle memory wait, flushed once on release
    do_reset("mw");
    ex_branch_taken = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) step("mw_frz");
    dmem_ready = 1;
    step("mw_rel");
    chk("mw_state_run", 32'(state), 32'd0);
    clear_inputs();
    step("mw_after");
    chk("mw_stall3", 32'(stall_cnt), 32'd3);
    chk("mw_flush1", 32'(flush_cnt), 32'd1);

    // timeout into ERROR, stuck until reset
    do_reset("to");
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 1 + TO; i++) step("to_wait");
    chk("to_state_err", 32'(state), 32'd2);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    dmem_req = 0; dmem_ready = 1;
    step("to_err_hold");
    chk("to_freeze", 32'(freeze), 32'd1);
    do_reset("to_exit");

    // stall counter saturates
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    for (int i = 0; i < SAT + 5; i++) step("sat");
    chk("sat_stall_max", 32'(stall_cnt), 32'd15);
    clear_inputs();
    do_reset("pre_rnd");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd_rst");
      end else begin
        id_rs1          = 5'($urandom_range(0, 3));
        id_rs2          = 5'($urandom_range(0, 3));
        ex_rd           = 5'($urandom_range(0, 3));
        id_uses_rs1     = 1'($urandom_range(0, 1));
        id_uses_rs2     = 1'($urandom_range(0, 1));
        ex_mem_read     = 1'($urandom_range(0, 1));
        ex_branch_taken = ($urandom_range(0, 4) == 0);
        dmem_req        = ($urandom_range(0, 3) == 0);
        dmem_ready      = 1'($urandom_range(0, 1));
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
